// File: rtl/fp_wb_arbiter_if.sv
// Shared types and the per-unit intermediate writeback interface for fp_wb_arbiter.
// The interface carries one unit's pre-normalization result; ack is driven by the arbiter.
package fp_wb_pkg;
  localparam int ID_W     = 4;
  localparam int FFLAGS_W = 5;
  localparam int CLZ_W    = 6;
  localparam int GRS_W    = 3;
  localparam int RD_W     = 32;
  localparam int RM_W     = 3;
  localparam int RSA_W    = 6;

  typedef struct packed {
    int unsigned flen;
    int unsigned xlen;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{flen: 32, xlen: 32};

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic                d2s;
    logic [FFLAGS_W-1:0] fflags;
    logic                carry;
    logic                safe;
    logic                hidden;
    logic [CLZ_W-1:0]    clz;
    logic [GRS_W-1:0]    grs;
    logic [RD_W-1:0]     rd;
    logic [RM_W-1:0]     rm;
    logic                expo_overflow;
    logic                subnormal;
    logic                right_shift;
    logic [RSA_W-1:0]    right_shift_amt;
    logic                ignore_max_expo;
  } fp_intermediate_t;
endpackage

interface fp_intermediate_wb_interface;
  // Handshake: a unit raises done with a stable payload; the transfer happens
  // on the rising edge of any cycle where ack is high. Payload may change only after that edge.
  logic                          done;
  logic                          ack;
  logic [fp_wb_pkg::ID_W-1:0]     id;
  logic                          d2s;
  logic [fp_wb_pkg::FFLAGS_W-1:0] fflags;
  logic                          carry;
  logic                          safe;
  logic                          hidden;
  logic [fp_wb_pkg::CLZ_W-1:0]    clz;
  logic [fp_wb_pkg::GRS_W-1:0]    grs;
  logic [fp_wb_pkg::RD_W-1:0]     rd;
  logic [fp_wb_pkg::RM_W-1:0]     rm;
  logic                          expo_overflow;
  logic                          subnormal;
  logic                          right_shift;
  logic [fp_wb_pkg::RSA_W-1:0]    right_shift_amt;
  logic                          ignore_max_expo;

  modport wb (
    input  done, id, d2s, fflags, carry, safe, hidden, clz, grs, rd, rm,
           expo_overflow, subnormal, right_shift, right_shift_amt, ignore_max_expo,
    output ack
  );

  modport unit (
    output done, id, d2s, fflags, carry, safe, hidden, clz, grs, rd, rm,
           expo_overflow, subnormal, right_shift, right_shift_amt, ignore_max_expo,
    input  ack
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter merging FP unit intermediate results into one normalization stream.
// Define FP_WB_ARB_SKID_EN for 2-entry output storage; default is a single register.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int          NUM_UNITS = 2,
  parameter cpu_config_t CONFIG    = EXAMPLE_CONFIG
) (
  input  logic                         clk,
  input  logic                         rst,
  fp_intermediate_wb_interface.wb      unit_wb [NUM_UNITS],
  output logic                         norm_valid,
  input  logic                         norm_ready,
  output fp_intermediate_t             norm_args,
  output logic [$clog2(NUM_UNITS)-1:0] norm_unit
);
  localparam int UW = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0] w_done;
  fp_intermediate_t     w_payload [NUM_UNITS];
  logic [UW-1:0]        w_grant_idx;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_grant;
  logic [UW-1:0]        r_last_grant;
  logic                 w_unused_cfg;

  assign w_unused_cfg = ^CONFIG;

  // First done unit strictly after last, wrapping around.
  function automatic logic [UW-1:0] rr_pick(input logic [UW-1:0] last,
                                            input logic [NUM_UNITS-1:0] done);
    logic [UW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_UNITS; off++) begin
      idx = (32'(last) + 32'(off)) % NUM_UNITS;
      if (!found && done[UW'(idx)]) begin
        pick  = UW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_grant_idx = rr_pick(r_last_grant, w_done);
  assign w_accept    = ~w_full | (norm_valid & norm_ready);
  assign w_grant     = w_accept & (|w_done) & ~rst;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign w_done[i]    = unit_wb[i].done;
    assign w_payload[i] = '{
      id:              unit_wb[i].id,
      d2s:             unit_wb[i].d2s,
      fflags:          unit_wb[i].fflags,
      carry:           unit_wb[i].carry,
      safe:            unit_wb[i].safe,
      hidden:          unit_wb[i].hidden,
      clz:             unit_wb[i].clz,
      grs:             unit_wb[i].grs,
      rd:              unit_wb[i].rd,
      rm:              unit_wb[i].rm,
      expo_overflow:   unit_wb[i].expo_overflow,
      subnormal:       unit_wb[i].subnormal,
      right_shift:     unit_wb[i].right_shift,
      right_shift_amt: unit_wb[i].right_shift_amt,
      ignore_max_expo: unit_wb[i].ignore_max_expo
    };
    assign unit_wb[i].ack = w_grant & (w_grant_idx == UW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= UW'(NUM_UNITS - 1);
    end else if (w_grant) begin
      r_last_grant <= w_grant_idx;
    end
  end

`ifdef FP_WB_ARB_SKID_EN
  fp_intermediate_t r_q_args [2];
  logic [UW-1:0]    r_q_unit [2];
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_full     = (r_count == 2'd2);
  assign w_pop      = (r_count != 2'd0) & norm_ready;
  assign norm_valid = (r_count != 2'd0);
  assign norm_args  = r_q_args[0];
  assign norm_unit  = r_q_unit[0];

  // Entry 0 is always the oldest; a pop shifts entry 1 down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_q_args[0] <= '0;
      r_q_args[1] <= '0;
      r_q_unit[0] <= '0;
      r_q_unit[1] <= '0;
    end else begin
      case ({w_pop, w_grant})
        2'b10: begin
          r_q_args[0] <= r_q_args[1];
          r_q_unit[0] <= r_q_unit[1];
          r_count     <= r_count - 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd0) begin
            r_q_args[0] <= w_payload[w_grant_idx];
            r_q_unit[0] <= w_grant_idx;
          end else begin
            r_q_args[1] <= w_payload[w_grant_idx];
            r_q_unit[1] <= w_grant_idx;
          end
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_args[0] <= w_payload[w_grant_idx];
            r_q_unit[0] <= w_grant_idx;
          end else begin
            r_q_args[0] <= r_q_args[1];
            r_q_unit[0] <= r_q_unit[1];
            r_q_args[1] <= w_payload[w_grant_idx];
            r_q_unit[1] <= w_grant_idx;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic             r_valid;
  fp_intermediate_t r_args;
  logic [UW-1:0]    r_unit;

  assign w_full     = r_valid;
  assign norm_valid = r_valid;
  assign norm_args  = r_args;
  assign norm_unit  = r_unit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_args  <= '0;
      r_unit  <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_args  <= w_payload[w_grant_idx];
      r_unit  <= w_grant_idx;
    end else if (norm_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: queue-level reference model plus directed scenarios.
module tb_fp_wb_arbiter;
  import fp_wb_pkg::*;

  localparam int N  = 2;
  localparam int UW = $clog2(N);
  localparam int W  = UW + $bits(fp_intermediate_t);
`ifdef FP_WB_ARB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             norm_valid;
  logic             norm_ready;
  fp_intermediate_t norm_args;
  logic [UW-1:0]    norm_unit;

  logic [N-1:0]     tb_done;
  logic [N-1:0]     tb_ack;
  fp_intermediate_t tb_args [N];

  int n_total = 0;
  int n_bad   = 0;
  int pend [N];
  int seq = 0;

  logic [W-1:0] exp_q[$];
  int           m_last;
  int           grant_log[$];
  int           drain_log[$];
  logic         nv_log[$];

  fp_intermediate_wb_interface u_wb [N] ();

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign u_wb[i].done            = tb_done[i];
    assign u_wb[i].id              = tb_args[i].id;
    assign u_wb[i].d2s             = tb_args[i].d2s;
    assign u_wb[i].fflags          = tb_args[i].fflags;
    assign u_wb[i].carry           = tb_args[i].carry;
    assign u_wb[i].safe            = tb_args[i].safe;
    assign u_wb[i].hidden          = tb_args[i].hidden;
    assign u_wb[i].clz             = tb_args[i].clz;
    assign u_wb[i].grs             = tb_args[i].grs;
    assign u_wb[i].rd              = tb_args[i].rd;
    assign u_wb[i].rm              = tb_args[i].rm;
    assign u_wb[i].expo_overflow   = tb_args[i].expo_overflow;
    assign u_wb[i].subnormal       = tb_args[i].subnormal;
    assign u_wb[i].right_shift     = tb_args[i].right_shift;
    assign u_wb[i].right_shift_amt = tb_args[i].right_shift_amt;
    assign u_wb[i].ignore_max_expo = tb_args[i].ignore_max_expo;
    assign tb_ack[i]               = u_wb[i].ack;
  end

  fp_wb_arbiter #(.NUM_UNITS(N), .CONFIG(EXAMPLE_CONFIG)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .unit_wb    (u_wb),
    .norm_valid (norm_valid),
    .norm_ready (norm_ready),
    .norm_args  (norm_args),
    .norm_unit  (norm_unit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic fp_intermediate_t mk_args(input int u, input int s);
    fp_intermediate_t a;
    logic [95:0]      r;
    r = {$urandom, $urandom, $urandom};
    a = r[$bits(fp_intermediate_t)-1:0];
    a.rd = {8'(u), 24'(s)};
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_unit(input int u, input int cnt);
    pend[u]    = cnt;
    tb_done[u] = (cnt > 0);
  endtask

  // ---------------- unit driver: new payload only after an ack ----------------
  initial begin
    logic [N-1:0] acked;
    for (int i = 0; i < N; i++) begin
      pend[i]    = 0;
      tb_args[i] = mk_args(i, 0);
    end
    tb_done = '0;
    forever begin
      @(negedge clk);
      acked = tb_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acked[i] && pend[i] > 0) begin
          pend[i]--;
          seq++;
          tb_args[i] = mk_args(i, seq);
        end
        tb_done[i] = (pend[i] > 0);
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  initial begin
    int           g;
    int           idx;
    logic [N-1:0] exp_ack;
    logic         accept;
    logic         do_pop;
    logic         do_push;
    logic [W-1:0] new_entry;
    m_last = N - 1;
    forever begin
      @(negedge clk);
      do_pop  = 1'b0;
      do_push = 1'b0;
      new_entry = '0;
      g = -1;
      if (rst) begin
        exp_q.delete();
        m_last = N - 1;
        chk("ack_in_reset", 128'(tb_ack), 128'(0));
        chk("valid_in_reset", 128'(norm_valid), 128'(0));
      end else begin
        accept = (exp_q.size() < DEPTH) || (exp_q.size() > 0 && norm_ready);
        if (accept) begin
          for (int off = 1; off <= N; off++) begin
            idx = (m_last + off) % N;
            if (g < 0 && tb_done[idx]) g = idx;
          end
        end
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        chk("ack", 128'(tb_ack), 128'(exp_ack));
        chk("norm_valid", 128'(norm_valid), 128'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          chk("norm_unit", 128'(norm_unit), 128'(exp_q[0][W-1 -: UW]));
          chk("norm_args", 128'(norm_args), 128'(exp_q[0][W-UW-1:0]));
        end
        nv_log.push_back(norm_valid);
        for (int i = 0; i < N; i++) if (tb_ack[i]) grant_log.push_back(i);
        if (norm_valid && norm_ready) drain_log.push_back(int'(norm_unit));
        do_pop  = (exp_q.size() > 0) && norm_ready;
        do_push = (g >= 0);
        if (g >= 0) new_entry = {UW'(g), tb_args[g]};
      end
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_last = N - 1;
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          exp_q.push_back(new_entry);
          m_last = g;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    fp_intermediate_t held;
    rst        = 1'b1;
    norm_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 128'(norm_valid), 128'(0));
    chk("rst_unit", 128'(norm_unit), 128'(0));
    chk("rst_args", 128'(norm_args), 128'(0));
    chk("rst_ack", 128'(tb_ack), 128'(0));
    rst = 1'b0;
    step();

    // single result from unit 1
    tb_args[1].rd = 32'h3F80_0000;
    norm_ready = 1'b1;
    set_unit(1, 1);
    #1 chk("first_ack", 128'(tb_ack), 128'(2'b10));
    step();
    chk("first_valid", 128'(norm_valid), 128'(1));
    chk("first_unit", 128'(norm_unit), 128'(1));
    chk("first_rd", 128'(norm_args.rd), 128'(32'h3F80_0000));

    // both units continuously done: alternating grants, no bubble
    grant_log.delete();
    nv_log.delete();
    set_unit(0, 100);
    set_unit(1, 100);
    repeat (6) step();
    chk("rr_count", 128'(grant_log.size()), 128'(6));
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk("rr_order", 128'(grant_log[k]), 128'(k % 2));
    for (int k = 0; k < nv_log.size(); k++)
      chk("rr_no_bubble", 128'(nv_log[k]), 128'(1));
    set_unit(0, 0);
    set_unit(1, 0);
    repeat (3) step();

    // stall with unit 0 done: storage fills, then acks stop and output holds
    norm_ready = 1'b0;
    grant_log.delete();
    set_unit(0, 5);
    step();
    held = norm_args;
    repeat (3) begin
      step();
      chk("stall_stable", 128'(norm_args), 128'(held));
    end
    chk("stall_acks", 128'(grant_log.size()), 128'(DEPTH));
    for (int k = 0; k < grant_log.size(); k++)
      chk("stall_unit", 128'(grant_log[k]), 128'(0));
    norm_ready = 1'b1;
    #1 chk("drain_and_ack", 128'(tb_ack), 128'(2'b01));
    step();
    set_unit(0, 0);
    repeat (3) step();

    // make unit 1 the last grant, then stall with both units done
    set_unit(1, 1);
    repeat (3) step();
    norm_ready = 1'b0;
    grant_log.delete();
    drain_log.delete();
    set_unit(0, 1);
    set_unit(1, 1);
    repeat (3) step();
    chk("skid_grants", 128'(grant_log.size()), 128'(DEPTH));
    for (int k = 0; k < grant_log.size(); k++)
      chk("skid_grant_order", 128'(grant_log[k]), 128'(k));
    norm_ready = 1'b1;
    repeat (4) step();
    chk("drain_count", 128'(drain_log.size()), 128'(2));
    for (int k = 0; k < drain_log.size(); k++)
      chk("drain_order", 128'(drain_log[k]), 128'(k));

    // reset while holding a result from unit 1
    norm_ready = 1'b0;
    set_unit(1, 3);
    step();
    chk("pre_rst_valid", 128'(norm_valid), 128'(1));
    set_unit(0, 3);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(norm_valid), 128'(0));
    chk("async_rst_ack", 128'(tb_ack), 128'(0));
    chk("async_rst_unit", 128'(norm_unit), 128'(0));
    chk("async_rst_args", 128'(norm_args), 128'(0));
    step();
    step();
    rst = 1'b0;
    #1 chk("post_rst_prio", 128'(tb_ack), 128'(2'b01));
    norm_ready = 1'b1;
    step();

    // mixed traffic with varying backpressure
    for (int c = 0; c < 60; c++) begin
      norm_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        int u;
        u = $urandom_range(0, N - 1);
        set_unit(u, pend[u] + $urandom_range(1, 3));
      end
      step();
    end
    norm_ready = 1'b1;
    repeat (20) step();
    chk("final_empty", 128'(norm_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
